// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the vector CPU pipeline:
// opcodes, func codes, subword widths and instruction field positions.
package cpu_isa_pkg;

   localparam logic [0:5] OP_RTYPE = 6'b101010;
   localparam logic [0:5] OP_VLD   = 6'b100000;
   localparam logic [0:5] OP_VSD   = 6'b100001;
   localparam logic [0:5] OP_VBEZ  = 6'b100010;
   localparam logic [0:5] OP_VBNEZ = 6'b100011;
   localparam logic [0:5] OP_VNOP  = 6'b111100;

   localparam logic [0:5] FN_AND   = 6'd1;
   localparam logic [0:5] FN_OR    = 6'd2;
   localparam logic [0:5] FN_XOR   = 6'd3;
   localparam logic [0:5] FN_NOT   = 6'd4;
   localparam logic [0:5] FN_MOV   = 6'd5;
   localparam logic [0:5] FN_ADD   = 6'd6;
   localparam logic [0:5] FN_SUB   = 6'd7;
   localparam logic [0:5] FN_MULEU = 6'd8;
   localparam logic [0:5] FN_MULOU = 6'd9;
   localparam logic [0:5] FN_SLL   = 6'd10;
   localparam logic [0:5] FN_SRL   = 6'd11;
   localparam logic [0:5] FN_SRA   = 6'd12;
   localparam logic [0:5] FN_RTTH  = 6'd13;
   localparam logic [0:5] FN_DIV   = 6'd14;
   localparam logic [0:5] FN_MOD   = 6'd15;
   localparam logic [0:5] FN_SQEU  = 6'd16;
   localparam logic [0:5] FN_SQOU  = 6'd17;
   localparam logic [0:5] FN_SQRT  = 6'd18;

   localparam logic [0:1] WW_B = 2'b00;
   localparam logic [0:1] WW_H = 2'b01;
   localparam logic [0:1] WW_W = 2'b10;
   localparam logic [0:1] WW_D = 2'b11;

   localparam int OP_HI   = 0;
   localparam int OP_LO   = 5;
   localparam int RD_HI   = 6;
   localparam int RD_LO   = 10;
   localparam int RA_HI   = 11;
   localparam int RA_LO   = 15;
   localparam int RB_HI   = 16;
   localparam int RB_LO   = 20;
   localparam int PPP_HI  = 21;
   localparam int PPP_LO  = 23;
   localparam int WW_HI   = 24;
   localparam int WW_LO   = 25;
   localparam int FUNC_HI = 26;
   localparam int FUNC_LO = 31;

   typedef struct packed {
      logic [0:4] rd;
      logic [0:4] ra;
      logic [0:4] rb;
      logic [0:2] ppp;
      logic [0:1] ww;
      logic       wr_en;
      logic       mem_en;
      logic       mem_wr_en;
      logic       bez;
      logic       bnez;
   } id_ctrl_t;

   function automatic logic func_writes(input logic [0:5] func);
      return (func >= FN_AND) && (func <= FN_SQRT);
   endfunction

endpackage

// File: rtl/decode_ctrl_comb.sv
// Combinational decode of one instruction word into the
// ID-stage control word.
module decode_ctrl_comb
   import cpu_isa_pkg::*;
(
   input  logic [0:31] inst,
   output id_ctrl_t    ctrl
);

   logic [0:5] op;
   logic [0:5] func;

   assign op   = inst[OP_HI:OP_LO];
   assign func = inst[FUNC_HI:FUNC_LO];

   always_comb begin
      ctrl    = '0;
      ctrl.rd = inst[RD_HI:RD_LO];
      ctrl.ra = inst[RA_HI:RA_LO];
      ctrl.rb = inst[RB_HI:RB_LO];
      unique case (1'b1)
         (op == OP_RTYPE): begin
            ctrl.ppp   = inst[PPP_HI:PPP_LO];
            ctrl.ww    = inst[WW_HI:WW_LO];
            ctrl.wr_en = func_writes(func);
         end
         (op == OP_VLD): begin
            ctrl.wr_en  = 1'b1;
            ctrl.mem_en = 1'b1;
         end
         (op == OP_VSD): begin
            ctrl.mem_en    = 1'b1;
            ctrl.mem_wr_en = 1'b1;
         end
         (op == OP_VBEZ):  ctrl.bez  = 1'b1;
         (op == OP_VBNEZ): ctrl.bnez = 1'b1;
         // VNOP and undefined opcodes leave every enable clear
         default: ;
      endcase
   end

endmodule

// File: rtl/decode_ctrl_stage.sv
// ID stage control decode with the ID/EX output register;
// a reset cycle presents a NOP downstream.
module decode_ctrl_stage
   import cpu_isa_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [0:31] inst,
   output logic [0:4]  ID_rD,
   output logic [0:4]  ID_rA,
   output logic [0:4]  ID_rB,
   output logic [0:2]  ID_ppp,
   output logic [0:1]  ID_WW,
   output logic        ID_wrEn,
   output logic        ID_memEn,
   output logic        ID_memwrEn,
   output logic        ID_decode_ctrl_bez,
   output logic        ID_decode_ctrl_bnez
);

   id_ctrl_t ctrl_d;
   id_ctrl_t ctrl_q;

   decode_ctrl_comb u_comb (
      .inst (inst),
      .ctrl (ctrl_d)
   );

   always_ff @(posedge clk) begin
      if (reset) ctrl_q <= '0;
      else       ctrl_q <= ctrl_d;
   end

   assign ID_rD               = ctrl_q.rd;
   assign ID_rA               = ctrl_q.ra;
   assign ID_rB               = ctrl_q.rb;
   assign ID_ppp              = ctrl_q.ppp;
   assign ID_WW               = ctrl_q.ww;
   assign ID_wrEn             = ctrl_q.wr_en;
   assign ID_memEn            = ctrl_q.mem_en;
   assign ID_memwrEn          = ctrl_q.mem_wr_en;
   assign ID_decode_ctrl_bez  = ctrl_q.bez;
   assign ID_decode_ctrl_bnez = ctrl_q.bnez;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Self-checking bench for decode_ctrl_stage: directed cases
// plus random instructions against a behavioural model.
module tb_decode_ctrl_stage;

   logic        clk;
   logic        reset;
   logic [0:31] inst;
   logic [0:4]  ID_rD, ID_rA, ID_rB;
   logic [0:2]  ID_ppp;
   logic [0:1]  ID_WW;
   logic        ID_wrEn, ID_memEn, ID_memwrEn;
   logic        ID_decode_ctrl_bez, ID_decode_ctrl_bnez;

   int errors = 0;
   int checks = 0;

   decode_ctrl_stage dut (
      .clk                 (clk),
      .reset               (reset),
      .inst                (inst),
      .ID_rD               (ID_rD),
      .ID_rA               (ID_rA),
      .ID_rB               (ID_rB),
      .ID_ppp              (ID_ppp),
      .ID_WW               (ID_WW),
      .ID_wrEn             (ID_wrEn),
      .ID_memEn            (ID_memEn),
      .ID_memwrEn          (ID_memwrEn),
      .ID_decode_ctrl_bez  (ID_decode_ctrl_bez),
      .ID_decode_ctrl_bnez (ID_decode_ctrl_bnez)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {rD,rA,rB,ppp,WW,wrEn,memEn,memwrEn,bez,bnez}
   function automatic logic [24:0] observed();
      return {ID_rD, ID_rA, ID_rB, ID_ppp, ID_WW,
              ID_wrEn, ID_memEn, ID_memwrEn,
              ID_decode_ctrl_bez, ID_decode_ctrl_bnez};
   endfunction

   function automatic logic [24:0] model(input logic [31:0] w,
                                         input bit r);
      int op, fn;
      logic [2:0] ppp;
      logic [1:0] ww;
      logic [4:0] en;
      if (r) return '0;
      op  = int'(w >> 26);
      fn  = int'(w % 64);
      ppp = 3'((w >> 8) % 8);
      ww  = 2'((w >> 6) % 4);
      en  = 5'b00000;
      if (op == 42) begin
         if (fn >= 1 && fn <= 18) en = 5'b10000;
      end else begin
         ppp = 3'b000;
         ww  = 2'b00;
         if (op == 32) en = 5'b11000;
         if (op == 33) en = 5'b01100;
         if (op == 34) en = 5'b00010;
         if (op == 35) en = 5'b00001;
      end
      return {5'((w >> 21) % 32), 5'((w >> 16) % 32),
              5'((w >> 11) % 32), ppp, ww, en};
   endfunction

   task automatic apply(input logic [31:0] w, input bit r);
      @(negedge clk);
      inst  = w;
      reset = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      apply(32'h8061_007F, 1'b1);
      checks++;
      if (observed() !== 25'd0) begin
         errors++;
         $display("FAIL reset_state got=%h exp=%h", observed(), 25'd0);
      end
   endtask

   task automatic test_rtype();
      logic [24:0] exp;
      apply({6'b101010, 5'd6, 5'd8, 5'd16, 3'b010, 2'b10, 6'b000110}, 1'b0);
      exp = {5'd6, 5'd8, 5'd16, 3'b010, 2'b10, 5'b10000};
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL rtype_add got=%h exp=%h", observed(), exp);
      end
      apply({6'b101010, 5'd6, 5'd8, 5'd16, 3'b010, 2'b10, 6'b001101}, 1'b0);
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL rtype_rtth got=%h exp=%h", observed(), exp);
      end
      apply({6'b101010, 5'd6, 5'd8, 5'd16, 3'b010, 2'b10, 6'b111111}, 1'b0);
      exp = {5'd6, 5'd8, 5'd16, 3'b010, 2'b10, 5'b00000};
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL rtype_func63 got=%h exp=%h", observed(), exp);
      end
      apply({6'b101010, 5'd1, 5'd2, 5'd3, 3'b111, 2'b11, 6'b010010}, 1'b0);
      exp = {5'd1, 5'd2, 5'd3, 3'b111, 2'b11, 5'b10000};
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL rtype_sqrt got=%h exp=%h", observed(), exp);
      end
      apply({6'b101010, 5'd1, 5'd2, 5'd3, 3'b111, 2'b11, 6'b010011}, 1'b0);
      exp = {5'd1, 5'd2, 5'd3, 3'b111, 2'b11, 5'b00000};
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL rtype_func19 got=%h exp=%h", observed(), exp);
      end
      apply({6'b101010, 5'd1, 5'd2, 5'd3, 3'b111, 2'b11, 6'b000000}, 1'b0);
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL rtype_func0 got=%h exp=%h", observed(), exp);
      end
   endtask

   task automatic test_mem();
      logic [24:0] exp;
      apply({6'b100000, 5'd3, 5'd8, 16'd127}, 1'b0);
      exp = {5'd3, 5'd8, 5'd0, 3'b000, 2'b00, 5'b11000};
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL vld got=%h exp=%h", observed(), exp);
      end
      apply({6'b100001, 5'd5, 5'd1, 16'd127}, 1'b0);
      exp = {5'd5, 5'd1, 5'd0, 3'b000, 2'b00, 5'b01100};
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL vsd got=%h exp=%h", observed(), exp);
      end
      apply({6'b100000, 5'd4, 5'd2, 16'hFFFF}, 1'b0);
      exp = {5'd4, 5'd2, 5'd31, 3'b000, 2'b00, 5'b11000};
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL vld_ppp_zero got=%h exp=%h", observed(), exp);
      end
   endtask

   task automatic test_branch();
      logic [24:0] exp;
      apply({6'b100010, 5'd7, 21'd0}, 1'b0);
      exp = {5'd7, 20'd0} | 25'b00010;
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL vbez got=%h exp=%h", observed(), exp);
      end
      apply({6'b100011, 5'd8, 21'd0}, 1'b0);
      exp = {5'd8, 20'd0} | 25'b00001;
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL vbnez got=%h exp=%h", observed(), exp);
      end
      apply({6'b111100, 5'd9, 21'h1FFFFF}, 1'b0);
      exp = {5'd9, 5'd31, 5'd31, 3'b000, 2'b00, 5'b00000};
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL vnop got=%h exp=%h", observed(), exp);
      end
   endtask

   task automatic test_reset_midstream();
      logic [24:0] exp;
      apply({6'b100000, 5'd3, 5'd8, 16'd127}, 1'b0);
      apply({6'b100000, 5'd10, 5'd11, 16'd1}, 1'b1);
      checks++;
      if (observed() !== 25'd0) begin
         errors++;
         $display("FAIL mid_reset got=%h exp=%h", observed(), 25'd0);
      end
      apply({6'b100000, 5'd12, 5'd13, 16'd2}, 1'b0);
      exp = {5'd12, 5'd13, 5'd0, 3'b000, 2'b00, 5'b11000};
      checks++;
      if (observed() !== exp) begin
         errors++;
         $display("FAIL post_reset got=%h exp=%h", observed(), exp);
      end
   endtask

   task automatic test_random();
      logic [31:0] w;
      bit r;
      logic [24:0] exp;
      int ops[7] = '{42, 32, 33, 34, 35, 60, 0};
      for (int i = 0; i < 300; i++) begin
         w = $urandom;
         if ($urandom_range(0, 3) != 0)
            w = {6'(ops[$urandom_range(0, 6)]), w[25:0]};
         if ($urandom_range(0, 1) == 0 && w[31:26] == 6'd42)
            w[5:0] = 6'($urandom_range(0, 20));
         r = ($urandom_range(0, 15) == 0);
         apply(w, r);
         exp = model(w, r);
         checks++;
         if (observed() !== exp) begin
            errors++;
            $display("FAIL random inst=%h rst=%0d got=%h exp=%h",
                     w, r, observed(), exp);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      inst  = '0;
      test_reset();
      test_rtype();
      test_mem();
      test_branch();
      test_reset_midstream();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
